// File: rtl/interfaz_alu_uart.sv
// rtl/interfaz_alu_uart.sv - UART-fed ALU front end: collects A, B and operator bytes, returns one result byte
// Optional feature macro: ERR_REPLY_EN (reply 'E' to an unsupported operator instead of silently dropping it)
module interfaz_alu_uart (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  input  logic       tx_done_tick,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic [7:0] dato_a,
  output logic [7:0] dato_b,
  output logic [7:0] ascii_op,
  input  logic [7:0] opcode_in,
  output logic [7:0] opcode,
  input  logic [7:0] alu_res,
  output logic       busy,
  output logic       ovr
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_DEC  = 3'd3,
    S_EXEC = 3'd4,
    S_TX   = 3'd5
  } state_t;

  state_t state;

`ifdef ERR_REPLY_EN
  // Marks that tx_data already holds the 'E' reply, so S_EXEC must not overwrite it with the ALU result
  logic err_reply;
`endif

  // Only S_A is able to start a new transaction
  assign busy = (state != S_A);

  // Transaction sequencer: byte capture, operator decode, one transmit request per transaction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_A;
      dato_a   <= 8'h00;
      dato_b   <= 8'h00;
      ascii_op <= 8'h00;
      opcode   <= 8'h00;
      tx_data  <= 8'h00;
      tx_start <= 1'b0;
      ovr      <= 1'b0;
`ifdef ERR_REPLY_EN
      err_reply <= 1'b0;
`endif
    end else begin
      tx_start <= 1'b0;
      case (state)
        S_A: begin
          if (rx_done_tick) begin
            dato_a <= rx_data;
            state  <= S_B;
          end
        end
        S_B: begin
          if (rx_done_tick) begin
            dato_b <= rx_data;
            state  <= S_OP;
          end
        end
        S_OP: begin
          if (rx_done_tick) begin
            ascii_op <= rx_data;
            state    <= S_DEC;
          end
        end
        S_DEC: begin
          // Bytes arriving while the result is being produced are dropped and flagged
          if (rx_done_tick) ovr <= 1'b1;
          if (opcode_in != 8'hFF) begin
            opcode <= opcode_in;
            state  <= S_EXEC;
          end else begin
`ifdef ERR_REPLY_EN
            tx_data   <= 8'h45;
            err_reply <= 1'b1;
            state     <= S_EXEC;
`else
            state     <= S_A;
`endif
          end
        end
        S_EXEC: begin
          if (rx_done_tick) ovr <= 1'b1;
`ifdef ERR_REPLY_EN
          if (!err_reply) tx_data <= alu_res;
          err_reply <= 1'b0;
`else
          tx_data <= alu_res;
`endif
          tx_start <= 1'b1;
          state    <= S_TX;
        end
        S_TX: begin
          // A coincident rx byte is still an overrun: the receiver outran the transmitter
          if (rx_done_tick) ovr <= 1'b1;
          if (tx_done_tick) state <= S_A;
        end
        default: state <= S_A;
      endcase
    end
  end

endmodule
